// File: rtl/uart_pkg.sv
// Shared FSM state encodings and counter-width helpers for the UART core.
// The PARITY states exist only when UART_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_e;

  function automatic int unsigned tick_cnt_w(input int unsigned oversample);
    return (oversample > 2) ? $clog2(oversample) : 1;
  endfunction

  function automatic int unsigned bit_cnt_w(input int unsigned data_bits);
    return $clog2(data_bits + 1);
  endfunction

  function automatic int unsigned div_cnt_w(input int unsigned clks);
    return (clks > 1) ? $clog2(clks) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-tick divider: one-cycle tick every CLKS_PER_TICK clocks, shared by TX and RX.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_TICK = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int unsigned DIV_W = div_cnt_w(CLKS_PER_TICK);
  localparam logic [DIV_W-1:0] RELOAD = DIV_W'(CLKS_PER_TICK - 1);

  logic [DIV_W-1:0] div_q;

  assign tick_o = (div_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      div_q <= RELOAD;
    else if (tick_o) div_q <= RELOAD;
    else             div_q <= div_q - DIV_W'(1);
  end

endmodule

// File: rtl/uart_core.sv
// Full-duplex UART: LSB-first TX and RX FSMs sharing one baud-tick generator.
// Optional parity bit on both directions when UART_PARITY_EN is defined.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned CLKS_PER_TICK = 1,
  parameter int unsigned STOP_BITS     = 1,
  parameter int unsigned PARITY_ODD    = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 rx_frame_err,
  output logic                 rx_parity_err,
  output logic                 rx_overrun
);

  if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 ||
      CLKS_PER_TICK < 1 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_bad_params
    $error("uart_core: illegal parameter value");
  end

  localparam int unsigned TICK_W = tick_cnt_w(OVERSAMPLE);
  localparam int unsigned BIT_W  = bit_cnt_w(DATA_BITS);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
`ifdef UART_PARITY_EN
  localparam logic PAR_ODD = 1'(PARITY_ODD);
`endif

  logic tick;

  uart_baud_gen #(.CLKS_PER_TICK(CLKS_PER_TICK)) u_baud_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_o (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q;
  logic                 tx_q, tx_ready_q;
  logic [DATA_BITS-1:0] tx_shift_q;
  logic [TICK_W-1:0]    tx_tick_q;
  logic [BIT_W-1:0]     tx_bit_q;
  logic                 tx_bit_end;
`ifdef UART_PARITY_EN
  logic                 tx_par_q;
`endif

  assign tx_bit_end = tick && (tx_tick_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_q       <= 1'b1;
      tx_ready_q <= 1'b1;
      tx_shift_q <= '0;
      tx_tick_q  <= '0;
      tx_bit_q   <= '0;
`ifdef UART_PARITY_EN
      tx_par_q   <= 1'b0;
`endif
    end else begin
      if (tick) tx_tick_q <= tx_bit_end ? TICK_LAST : tx_tick_q - TICK_W'(1);
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_valid) begin
            // Restart the period counter so the start bit is a full bit period.
            tx_state_q <= TX_START;
            tx_q       <= 1'b0;
            tx_ready_q <= 1'b0;
            tx_shift_q <= tx_data;
            tx_tick_q  <= TICK_LAST;
`ifdef UART_PARITY_EN
            tx_par_q   <= (^tx_data) ^ PAR_ODD;
`endif
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_DATA;
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= tx_shift_q >> 1;
            tx_bit_q   <= BIT_LAST;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            if (tx_bit_q == '0) begin
`ifdef UART_PARITY_EN
              tx_state_q <= TX_PARITY;
              tx_q       <= tx_par_q;
`else
              tx_state_q <= TX_STOP;
              tx_q       <= 1'b1;
              tx_bit_q   <= STOP_LAST;
`endif
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= tx_shift_q >> 1;
              tx_bit_q   <= tx_bit_q - BIT_W'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        TX_PARITY: begin
          if (tx_bit_end) begin
            tx_state_q <= TX_STOP;
            tx_q       <= 1'b1;
            tx_bit_q   <= STOP_LAST;
          end
        end
`endif
        TX_STOP: begin
          if (tx_bit_end) begin
            if (tx_bit_q == '0) begin
              tx_state_q <= TX_IDLE;
              tx_ready_q <= 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q - BIT_W'(1);
            end
          end
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_q       <= 1'b1;
          tx_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = tx_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = ~tx_ready_q;

  // ---------------- receiver ----------------
  logic                 rx_meta_q, rx_sync_q;
  rx_state_e            rx_state_q;
  logic                 rx_armed_q;
  logic [DATA_BITS-1:0] rx_shift_q, rx_data_q;
  logic [TICK_W-1:0]    rx_tick_q;
  logic [BIT_W-1:0]     rx_bit_q;
  logic                 rx_valid_q, rx_frame_err_q, rx_overrun_q;
  logic                 rx_bit_end;
`ifdef UART_PARITY_EN
  logic                 rx_par_pend_q, rx_parity_err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
    end
  end

  assign rx_bit_end = tick && (rx_tick_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q      <= RX_IDLE;
      rx_armed_q      <= 1'b0;
      rx_shift_q      <= '0;
      rx_data_q       <= '0;
      rx_tick_q       <= '0;
      rx_bit_q        <= '0;
      rx_valid_q      <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_overrun_q    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_pend_q   <= 1'b0;
      rx_parity_err_q <= 1'b0;
`endif
    end else begin
      rx_overrun_q <= 1'b0;
      if (rx_valid_q && rx_ready) rx_valid_q <= 1'b0;
      if (tick) rx_tick_q <= rx_bit_end ? TICK_LAST : rx_tick_q - TICK_W'(1);
      case (rx_state_q)
        RX_IDLE: begin
          // Armed only after a high level, so a held-low line cannot retrigger.
          rx_armed_q <= rx_sync_q;
          if (rx_armed_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_tick_q  <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_bit_end) begin
            if (rx_sync_q) begin
              rx_state_q <= RX_IDLE;
              rx_armed_q <= 1'b1;
            end else begin
              rx_state_q <= RX_DATA;
              rx_bit_q   <= BIT_LAST;
            end
          end
        end
        RX_DATA: begin
          if (rx_bit_end) begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
            if (rx_bit_q == '0) begin
`ifdef UART_PARITY_EN
              rx_state_q <= RX_PARITY;
`else
              rx_state_q <= RX_STOP;
`endif
            end else begin
              rx_bit_q <= rx_bit_q - BIT_W'(1);
            end
          end
        end
`ifdef UART_PARITY_EN
        RX_PARITY: begin
          if (rx_bit_end) begin
            rx_state_q    <= RX_STOP;
            rx_par_pend_q <= ((^rx_shift_q) ^ rx_sync_q) != PAR_ODD;
          end
        end
`endif
        RX_STOP: begin
          if (rx_bit_end) begin
            rx_state_q <= RX_IDLE;
            rx_armed_q <= rx_sync_q;
            if (!rx_valid_q || rx_ready) begin
              rx_valid_q      <= 1'b1;
              rx_data_q       <= rx_shift_q;
              rx_frame_err_q  <= ~rx_sync_q;
`ifdef UART_PARITY_EN
              rx_parity_err_q <= rx_par_pend_q;
`endif
            end else begin
              rx_overrun_q <= 1'b1;
            end
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign rx_frame_err = rx_frame_err_q;
  assign rx_overrun   = rx_overrun_q;
`ifdef UART_PARITY_EN
  assign rx_parity_err = rx_parity_err_q;
`else
  assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core (DATA_BITS=8, OVERSAMPLE=4, CLKS_PER_TICK=1, one stop bit).
// Parity cases are included when UART_PARITY_EN is defined.
module tb_uart_core;

  localparam int OS = 4;
`ifdef UART_PARITY_EN
  localparam int FRAME_N = 11;
`else
  localparam int FRAME_N = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx, tx_busy;
  logic       rx, rx_drv, loop_en;
  logic [7:0] rx_data;
  logic       rx_valid, rx_ready, rx_frame_err, rx_parity_err, rx_overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_ovr    = 0;

  always #5 clk = ~clk;

  assign rx = loop_en ? tx : rx_drv;

  uart_core #(
    .DATA_BITS(8), .OVERSAMPLE(OS), .CLKS_PER_TICK(1), .STOP_BITS(1), .PARITY_ODD(0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_frame_err (rx_frame_err),
    .rx_parity_err(rx_parity_err),
    .rx_overrun   (rx_overrun)
  );

  always @(negedge clk) if (rx_overrun) n_ovr++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Frame bits LSB first: start, data, [parity], stop. Bit 10 is never sent without parity.
  function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic stop, input logic bad_par);
`ifdef UART_PARITY_EN
    return {stop, (^d) ^ bad_par, d, 1'b0};
`else
    return {bad_par, stop, d, 1'b0};
`endif
  endfunction

  task automatic tx_send(input logic [7:0] d);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic rx_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx_drv = bits[i];
      repeat (OS) @(negedge clk);
    end
    rx_drv = 1'b1;
  endtask

  task automatic wait_rx_valid(input string tag, input int budget);
    int i = 0;
    while (!rx_valid && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_rx_valid"}, rx_valid, 1);
  endtask

  task automatic wait_tx_idle(input string tag, input int budget);
    int i = 0;
    while (!tx_ready && i < budget) begin
      @(negedge clk);
      i++;
    end
    check({tag, "_tx_idle"}, tx_ready, 1);
  endtask

  task automatic accept_rx(input string tag);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    check({tag, "_rx_valid_cleared"}, rx_valid, 0);
  endtask

  initial begin
    logic [10:0] exp_frame;
    logic        seen;
    int          ovr0;

    tx_data  = '0;
    tx_valid = 1'b0;
    rx_ready = 1'b0;
    rx_drv   = 1'b1;
    loop_en  = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 0);
    check("rst_frame_err", rx_frame_err, 0);
    check("rst_parity_err", rx_parity_err, 0);
    check("rst_overrun", rx_overrun, 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // TX 0xA5: every sample of the frame, ready low for the whole frame
    exp_frame = mk_frame(8'hA5, 1'b1, 1'b0);
    tx_send(8'hA5);
    check("tx_a5_busy", tx_busy, 1);
    for (int k = 0; k < FRAME_N * OS; k++) begin
      check($sformatf("tx_a5_bit%0d_cyc%0d", k / OS, k), tx, exp_frame[k / OS]);
      check($sformatf("tx_a5_ready_low_cyc%0d", k), tx_ready, 0);
      @(negedge clk);
    end
    check("tx_a5_ready_after", tx_ready, 1);
    check("tx_a5_busy_after", tx_busy, 0);
    check("tx_a5_idle_high", tx, 1);

    // Loopback 0x3C
    ovr0 = n_ovr;
    loop_en = 1'b1;
    tx_send(8'h3C);
    wait_rx_valid("loop", 20 * OS);
    check("loop_data", rx_data, 8'h3C);
    check("loop_frame_err", rx_frame_err, 0);
    check("loop_parity_err", rx_parity_err, 0);
    check("loop_no_overrun", n_ovr - ovr0, 0);
    wait_tx_idle("loop", 20 * OS);
    accept_rx("loop");
    loop_en = 1'b0;
    repeat (4) @(negedge clk);

    // One-cycle glitch: false start, nothing delivered
    rx_drv = 1'b0;
    @(negedge clk);
    rx_drv = 1'b1;
    seen = 1'b0;
    repeat (FRAME_N * OS) begin
      @(negedge clk);
      seen |= rx_valid;
    end
    check("glitch_no_valid", seen, 0);

    // 0x00 with stop forced low: framing error
    rx_bits(mk_frame(8'h00, 1'b0, 1'b0), FRAME_N);
    wait_rx_valid("ferr", 4 * OS);
    check("ferr_data", rx_data, 8'h00);
    check("ferr_frame_err", rx_frame_err, 1);
    check("ferr_parity_err", rx_parity_err, 0);
    accept_rx("ferr");
    repeat (2 * OS) @(negedge clk);

    // Overrun: 0x11 held, 0x22 dropped with one overrun pulse
    ovr0 = n_ovr;
    rx_bits(mk_frame(8'h11, 1'b1, 1'b0), FRAME_N);
    repeat (OS) @(negedge clk);
    rx_bits(mk_frame(8'h22, 1'b1, 1'b0), FRAME_N);
    repeat (2 * OS) @(negedge clk);
    check("ovr_valid_held", rx_valid, 1);
    check("ovr_data_kept", rx_data, 8'h11);
    check("ovr_frame_err", rx_frame_err, 0);
    check("ovr_pulse_count", n_ovr - ovr0, 1);
    accept_rx("ovr");
    repeat (OS) @(negedge clk);

`ifdef UART_PARITY_EN
    // TX 0x07 even parity: parity bit (frame bit 9) is 1
    tx_send(8'h07);
    repeat (9 * OS + OS / 2) @(negedge clk);
    check("par_tx07_bit", tx, 1);
    wait_tx_idle("par_tx07", 4 * OS);
    repeat (OS) @(negedge clk);

    // RX 0x07 with parity bit 0
    rx_bits(mk_frame(8'h07, 1'b1, 1'b1), FRAME_N);
    wait_rx_valid("par_rx07", 4 * OS);
    check("par_rx07_data", rx_data, 8'h07);
    check("par_rx07_parity_err", rx_parity_err, 1);
    check("par_rx07_frame_err", rx_frame_err, 0);
    accept_rx("par_rx07");
    repeat (OS) @(negedge clk);
`endif

    // Reset during DATA of 0xFF (looped back so RX is mid-frame too)
    loop_en = 1'b1;
    tx_send(8'hFF);
    repeat (2 * OS) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid_tx", tx, 1);
    check("rstmid_tx_ready", tx_ready, 1);
    check("rstmid_rx_valid", rx_valid, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (FRAME_N * OS) begin
      @(negedge clk);
      seen |= rx_valid;
    end
    check("rstmid_no_valid", seen, 0);
    tx_send(8'h5A);
    wait_rx_valid("rstmid_next", 20 * OS);
    check("rstmid_next_data", rx_data, 8'h5A);
    check("rstmid_next_frame_err", rx_frame_err, 0);
    wait_tx_idle("rstmid_next", 20 * OS);
    accept_rx("rstmid_next");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, %0d of %0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
Parametrised full-duplex UART: one transmitter and one receiver sharing a baud-tick generator.
- Data width, oversampling, baud divider and stop-bit count are configurable.
- Frames are LSB-first.
- Valid/ready handshakes on both byte interfaces.
- Receiver reports framing, parity and overrun errors.
- Sits between the host-side logic (byte producer/consumer) and the serial pins.

Parameters:
DATA_BITS, 8, payload bits per frame, legal 5..9
OVERSAMPLE, 16, baud ticks per bit period, even, >=4
CLKS_PER_TICK, 1, clk cycles per baud tick, >=1
STOP_BITS, 1, stop bits transmitted/checked, 1 or 2
PARITY_ODD, 0, parity sense when UART_PARITY_EN defined: 0 even, 1 odd

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
tx_data  in  DATA_BITS  byte to send
tx_valid  in  1  tx_data valid
tx_ready  out  1  transmitter idle, accepts byte
tx  out  1  serial out, idle high
tx_busy  out  1  frame in progress
rx  in  1  serial in, asynchronous to clk
rx_data  out  DATA_BITS  received byte
rx_valid  out  1  rx_data valid, held until accepted
rx_ready  in  1  consumer accepts rx_data
rx_frame_err  out  1  stop bit sampled low; qualified by rx_valid
rx_parity_err  out  1  parity mismatch; qualified by rx_valid, 0 without feature
rx_overrun  out  1  one-cycle pulse: frame completed while rx_valid still high

Behaviour:
- Reset values: tx=1, tx_ready=1, tx_busy=0, rx_valid=0, rx_data=0, all error outputs 0.
- Reset asserted mid-frame: both FSMs return to IDLE immediately; tick counters cleared; any partial byte is discarded.
- Tick generator:
  - Counter 0..CLKS_PER_TICK-1; tick pulses one clk cycle on wrap.
  - CLKS_PER_TICK=1 means tick every cycle.
  - Bit period = OVERSAMPLE*CLKS_PER_TICK clk cycles.
- TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - Accept only when tx_valid && tx_ready; tx_data is latched into a shift register at acceptance.
  - tx_ready=1 only in IDLE; it drops the cycle after acceptance.
  - tx goes low on the clk edge following acceptance (1-cycle latency). The bit counter restarts at acceptance, so the start bit lasts exactly one bit period.
  - DATA shifts out bit 0 first, DATA_BITS bit periods.
  - STOP drives 1 for STOP_BITS bit periods, then returns to IDLE with tx_ready=1. Back-to-back frames are therefore separated only by the stop bits.
  - tx_busy = !tx_ready.
- RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
  - rx passes through a 2-flop synchroniser (2-cycle input latency); all sampling uses the synchronised value.
  - IDLE: synchronised rx=0 enters START with the tick counter cleared.
  - START: sample at OVERSAMPLE/2 ticks. If rx=1, it is a false start: return to IDLE, no output.
  - DATA: sample every OVERSAMPLE ticks thereafter (bit midpoints), LSB first.
  - STOP: sample the first stop bit only at its midpoint. A 0 sets the frame error. Return to IDLE immediately after that sample, which allows a resync on an early start edge.
  - Frame completion: if rx_valid=0, load rx_data and the error flags and set rx_valid the next cycle.
  - If rx_valid=1 at completion: keep the old data and flags, drop the new frame, pulse rx_overrun.
  - rx_valid clears on the cycle after rx_valid && rx_ready.
  - If acceptance coincides with completion, the new frame is loaded and rx_valid stays 1, with no overrun.
- Break condition (rx held low): framing error frame delivered. The FSM re-arms only after rx returns high in IDLE; a new start requires a high-to-low edge.

Optional Feature:
UART_PARITY_EN
- Defined:
  - One parity bit is inserted after the data bits on TX and checked on RX.
  - Even parity (PARITY_ODD=0): XOR of data plus parity = 0. Odd parity (PARITY_ODD=1): that XOR = 1.
  - rx_parity_err is set on mismatch.
- Undefined: no PARITY state is present; the frame is start+data+stop; rx_parity_err is tied to 0.

Decomposition:
- Package uart_pkg:
  - TX and RX FSM state enums (IDLE, START, DATA, PARITY, STOP).
  - Width-helper constants derived from the parameters: tick counter width $clog2(OVERSAMPLE), bit counter width $clog2(DATA_BITS+1).
- Sub-module uart_baud_gen: divider producing the tick pulse; instantiated once and shared by TX and RX.

Test Plan:
- Common setup: DATA_BITS=8, OVERSAMPLE=4, CLKS_PER_TICK=1, STOP_BITS=1, no parity.
- TX 0xA5: send tx_data=0xA5 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each 4 clk; tx_ready is low 40 cycles, then 1.
- Loopback 0x3C: tie tx to rx -> rx_valid rises with rx_data=0x3C and all error flags 0.
- False start and framing error:
  - 1-cycle low glitch on rx -> no rx_valid.
  - Frame 0x00 with stop bit forced 0 -> rx_valid=1, rx_frame_err=1.
- Overrun: two frames 0x11, 0x22 with rx_ready=0 -> rx_data stays 0x11, one rx_overrun pulse; rx_ready=1 then clears rx_valid.
- Parity (UART_PARITY_EN, PARITY_ODD=0):
  - TX 0x07 -> parity bit 1.
  - RX 0x07 with parity bit 0 -> rx_parity_err=1.
- Reset mid-frame: assert rst_n=0 during DATA of 0xFF -> tx=1 and tx_ready=1 immediately; no rx_valid; the next frame after release is received correctly.
